// File: rtl/demux_dispatcher_if.sv
// Producer/consumer handshake bundle for demux_dispatcher: one input stream,
// one shared data bus with per-lane valid/ready.
interface demux_dispatcher_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       sel;

    // slave: the dispatcher itself
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel
    );

    // master: the surrounding producer and lanes
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel
    );
endinterface

// File: rtl/demux_dispatcher.sv
// One-word holding stage that routes each word to one of four lanes, either a
// fixed lane or a work-conserving round-robin pick, with saturating lane counts.
module demux_dispatcher #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_dispatcher_if.slave    bus,
    input  logic                 mode,
    input  logic [1:0]           fix_sel,
    input  logic                 clr_cnt,
    output logic [4*CNT_W-1:0]   cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [1:0]       sel_reg, sel_next;
    logic [3:0]       valid_reg, valid_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic             out_fire, in_fire, in_ready;
    logic [1:0]       lane;

    assign out_fire = (state_reg == FULL) && bus.out_ready[sel_reg];
    assign in_ready = !rst && ((state_reg == EMPTY) || out_fire);
    assign in_fire  = bus.in_valid && in_ready;

    // A same-cycle refill searches from the pointer as it will be after the drain.
    assign ptr_next = out_fire ? 2'(sel_reg + 2'd1) : ptr_reg;

    always_comb begin
        lane = ptr_next;
        if (mode) begin
            lane = fix_sel;
        end else begin
            // Descending scan so the smallest circular offset wins.
            for (int i = 3; i >= 0; i--) begin
                if (bus.out_ready[2'(ptr_next + 2'(i))]) begin
                    lane = 2'(ptr_next + 2'(i));
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        sel_next   = sel_reg;
        valid_next = valid_reg;
        if (in_fire) begin
            state_next = FULL;
            data_next  = bus.in_data;
            sel_next   = lane;
            valid_next = 4'b0001 << lane;
        end else if (out_fire) begin
            state_next = EMPTY;
            valid_next = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            sel_reg   <= '0;
            valid_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_reg;
    assign bus.out_valid = valid_reg;
    assign bus.sel       = sel_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (clr_cnt) begin
                    cnt_reg <= '0;
                end else if (out_fire && (sel_reg == 2'(gi)) && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
endmodule

// File: tb/tb_demux_dispatcher.sv
// Randomized and directed checking of demux_dispatcher against a transaction-level model.
module tb_demux_dispatcher;
    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic [1:0] fix_sel = 2'd0;
    logic clr_cnt = 1'b0;
    logic [4*CNT_W-1:0] cnt;

    demux_dispatcher_if #(.WIDTH(WIDTH)) bus ();

    demux_dispatcher #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mode    (mode),
        .fix_sel (fix_sel),
        .clr_cnt (clr_cnt),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a one-slot buffer plus a lane pointer and four counters.
    bit         m_held;
    logic [7:0] m_data;
    int         m_lane;
    int         m_ptr;
    int         m_cnt [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 0;
        m_data = 8'h00;
        m_lane = 0;
        m_ptr  = 0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    function automatic logic [7:0] exp_cnt();
        logic [7:0] e;
        for (int k = 0; k < 4; k++) e[k*CNT_W +: CNT_W] = 2'(m_cnt[k]);
        return e;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input bit iv, input logic [7:0] din, input bit md,
                        input logic [1:0] fs, input logic [3:0] ordy, input bit clr);
        bit ofire, irdy, ifire;
        int pick;
        bus.in_valid  = iv;
        bus.in_data   = din;
        bus.out_ready = ordy;
        mode          = md;
        fix_sel       = fs;
        clr_cnt       = clr;
        @(negedge clk);
        ofire = m_held && ordy[m_lane];
        irdy  = !m_held || ofire;
        ifire = iv && irdy;
        chk("out_valid", 32'(bus.out_valid), m_held ? 32'(1 << m_lane) : 32'd0);
        chk("sel",       32'(bus.sel),       32'(m_lane));
        chk("out_data",  32'(bus.out_data),  32'(m_data));
        chk("in_ready",  32'(bus.in_ready),  32'(irdy));
        chk("cnt",       32'(cnt),           32'(exp_cnt()));
        if (clr) begin
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else if (ofire && m_cnt[m_lane] < CMAX) begin
            m_cnt[m_lane]++;
        end
        if (ofire) m_ptr = (m_lane + 1) % 4;
        if (ifire) begin
            pick = m_ptr;
            if (md) begin
                pick = int'(fs);
            end else begin
                for (int off = 0; off < 4; off++) begin
                    if (ordy[(m_ptr + off) % 4]) begin
                        pick = (m_ptr + off) % 4;
                        break;
                    end
                end
            end
            m_held = 1;
            m_lane = pick;
            m_data = din;
        end else if (ofire) begin
            m_held = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
        model_reset();
        #23 rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill, then reset asynchronously while holding a word.
        step(1, 8'h77, 1, 2'd2, 4'b0000, 0);
        step(0, 8'h00, 1, 2'd2, 4'b0000, 0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sel",       32'(bus.sel),       32'd0);
        chk("rst_cnt",       32'(cnt),           32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin with all lanes ready, back-to-back.
        for (int i = 0; i < 6; i++) step(1, 8'hA0 + 8'(i), 0, 2'd0, 4'b1111, 0);
        step(0, 8'h00, 0, 2'd0, 4'b1111, 0);
        chk("rr_cnt", 32'(cnt), 32'({2'd1, 2'd1, 2'd2, 2'd2}));

        // Move pointer to 1, then work-conserving skip to lane 2.
        step(1, 8'h11, 1, 2'd0, 4'b1111, 0);
        step(0, 8'h00, 1, 2'd0, 4'b1111, 0);
        step(1, 8'h55, 0, 2'd0, 4'b0100, 0);
        chk("skip_sel",   32'(bus.sel),       32'd2);
        chk("skip_valid", 32'(bus.out_valid), 32'b0100);
        step(1, 8'h56, 0, 2'd0, 4'b1111, 0);
        step(0, 8'h00, 0, 2'd0, 4'b1111, 0);

        // Stall on lane 3 while fix_sel toggles.
        step(1, 8'h3C, 1, 2'd3, 4'b0000, 1);
        for (int i = 0; i < 5; i++) step(1, 8'hEE, 1, 2'(i), 4'b0000, 0);
        step(0, 8'h00, 1, 2'd0, 4'b1000, 0);
        step(0, 8'h00, 1, 2'd0, 4'b0000, 0);

        // Pointer to 2, then capture with no lane ready.
        step(1, 8'h21, 1, 2'd1, 4'b1111, 0);
        step(0, 8'h00, 1, 2'd1, 4'b1111, 0);
        step(1, 8'h99, 0, 2'd0, 4'b0000, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 2'd0, 4'b0001, 0);
        step(0, 8'h00, 0, 2'd0, 4'b0100, 0);

        // Saturate lane 1, then clear together with a lane-1 fire.
        for (int i = 0; i < 5; i++) step(1, 8'h40 + 8'(i), 1, 2'd1, 4'b0010, 0);
        step(0, 8'h00, 1, 2'd1, 4'b0010, 0);
        chk("sat_cnt1", 32'(cnt[1*CNT_W +: CNT_W]), 32'd3);
        step(1, 8'h4F, 1, 2'd1, 4'b0010, 0);
        step(0, 8'h00, 1, 2'd1, 4'b0010, 1);
        chk("clr_cnt1", 32'(cnt[1*CNT_W +: CNT_W]), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 3) != 0), 8'($urandom),
                 bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom), bit'($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_dispatcher.md
# demux_dispatcher

Controller that sequences a shared 1-to-4 demultiplexer. It accepts a single valid/ready input stream, holds one word, and routes it to one of four downstream lanes. The lane is either a fixed lane or a work-conserving round-robin choice, and the block keeps a saturating per-lane transfer count. It sits between a single producer and four consumer lanes that share one data bus, with per-lane valid qualifying that bus.

## Interface
- `WIDTH`, default 8: data word width.
- `CNT_W`, default 8: width of each per-lane transfer counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  input word.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word this cycle (combinational).
- `mode`  in  1  0 = round-robin lane choice; 1 = fixed lane `fix_sel`.
- `fix_sel`  in  2  target lane when `mode`=1.
- `out_data`  out  WIDTH  held word, broadcast to all lanes (registered).
- `out_valid`  out  4  one-hot or zero; bit k = word offered to lane k (registered).
- `out_ready`  in  4  per-lane ready.
- `sel`  out  2  lane of the currently held word (registered).
- `clr_cnt`  in  1  synchronous clear of all counters.
- `cnt`  out  4*CNT_W  lane k count in bits [k*CNT_W +: CNT_W].

## Operation
- FSM with two states:
  - EMPTY: nothing held.
  - FULL: one word held; `out_valid[sel]`=1, all other bits 0.
- Output fire: FULL and `out_ready[sel]`=1. Input fire: `in_valid` and `in_ready`.
- `in_ready` = !rst and (EMPTY or output fire), i.e. refill in the same cycle as drain.
- Transitions:
  - EMPTY to FULL on input fire.
  - FULL to EMPTY on output fire without input fire.
  - FULL stays FULL on output fire with input fire (back-to-back), or with no output fire.
- On input fire: `out_data` <= `in_data`, and `sel` <= the chosen lane.
- Lane choice is evaluated in the capture cycle:
  - `mode`=1: lane = `fix_sel`.
  - `mode`=0: lane = first k in circular order `ptr`, `ptr`+1, … with `out_ready[k]`=1.
  - `mode`=0, no lane ready: lane = `ptr`.
- `ptr` (2-bit, internal): on output fire, `ptr` <= `sel`+1 (mod 4, wraps 3 to 0).
  - For a same-cycle refill, the lane search uses this updated value, `sel`+1, as its start.
  - `mode`=1 transfers update `ptr` the same way.
- While FULL without output fire, `out_data`, `sel` and `out_valid` are stable. Changes to `mode`, `fix_sel` or `out_ready` never retarget a held word.
- Counters:
  - On output fire, `cnt[sel]` increments, saturating at 2^CNT_W−1.
  - `clr_cnt`=1 zeroes all counters and wins over a same-cycle increment.
- Reset values: state EMPTY, `out_valid`=0, `out_data`=0, `sel`=0, `ptr`=0, all `cnt`=0, `in_ready`=0 while `rst` is high.
- Reset mid-transfer: the held word is discarded, with no output fire and no count.

## Timing
- Input-to-output latency: 1 cycle. A word captured at edge N is offered from the cycle after edge N.
- Throughput: 1 word/cycle when the target lanes stay ready (drain and refill in the same cycle).
- Handshake rules:
  - `in_ready` depends combinationally on state, `sel` and `out_ready`.
  - There is no combinational path from `in_valid` to `out_valid`.
- Counter outputs reflect a transfer from the cycle after its output-fire edge.
- Asynchronous reset takes effect immediately. The first capture is possible at the first rising edge after `rst` deasserts.

## Test plan
- **Reset.** Assert `rst` mid-cycle while FULL. Require `out_valid`=0000, `sel`=0, `cnt`=0, `in_ready`=0 immediately. After release: `in_ready`=1.
- **Round-robin, all lanes ready.** `mode`=0, `out_ready`=1111, stream 0xA0–0xA5 on consecutive cycles. Require:
  - lanes 0,1,2,3,0,1, one word per cycle;
  - each word on `out_data` exactly 1 cycle after capture;
  - final `cnt` = 2,2,1,1.
- **Work-conserving skip.** `mode`=0, `ptr`=1, `out_ready`=0100, send 0x55. Require `sel`=2 and `out_valid`=0100. The next word starts its search at lane 3.
- **Stall and hold.** `mode`=1, `fix_sel`=3, `out_ready`=0000, send 0x3C, then hold `out_ready` low for 5 cycles while toggling `fix_sel`. Require:
  - `out_valid`=1000, `out_data`=0x3C, `in_ready`=0 throughout;
  - `out_ready[3]`=1 completes the transfer, `in_ready`=1 that cycle, and `cnt[3]`=1.
- **No lane ready.** `mode`=0, `ptr`=2, `out_ready`=0000 at capture. Require `sel`=2 is held even when lane 0 later becomes ready.
- **Counter saturation and clear.** `CNT_W`=2, 5 transfers to lane 1. Require `cnt[1]`=3. Then assert `clr_cnt` together with a lane-1 fire. Require `cnt[1]`=0.
